// File: rtl/ofifo_pkg.sv
// Shared constants for the output FIFO and its neighbours (sfp, PSUM SRAM wrapper).
package ofifo_pkg;

    localparam int COL_DEF     = 8;
    localparam int PSUM_BW_DEF = 16;
    localparam int DEPTH_DEF   = 64;

    // Pointer width: address bits plus one wrap bit.
    localparam int PTR_BW = $clog2(DEPTH_DEF) + 1;

    // Width of one lane slice in the packed row bus.
    localparam int LANE_W = PSUM_BW_DEF;

    // Pointer width for a non-default depth.
    function automatic int ptr_bw_f(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ofifo_lane.sv
// One FIFO lane: circular buffer with wrap-bit pointers and a combinational head read.
module ofifo_lane
    import ofifo_pkg::*;
#(
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int depth   = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr,
    input  logic [psum_bw-1:0] din,
    input  logic               rd,      // effective read only; caller guarantees non-empty
    output logic [psum_bw-1:0] dout,
    output logic               empty,
    output logic               full
);

    localparam int PW = ptr_bw_f(depth);
    localparam int AW = PW - 1;

    logic [psum_bw-1:0] mem_q [depth];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic               wr_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // Accept a write unless full with no pop freeing a slot this cycle.
    always_comb begin
        wr_en    = wr & (~full | rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd)    rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Pointer registers; reset empties the lane.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ofifo.sv
// Output FIFO: per-column lanes written independently, popped one full row at a time.
module ofifo
    import ofifo_pkg::*;
#(
    parameter int col     = COL_DEF,
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int depth   = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [col-1:0]         wr,
    input  logic [col*psum_bw-1:0] in,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_ovf,
    output logic                   o_udf
);

    logic [col-1:0] empty;
    logic [col-1:0] full;
    logic           rd_eff;
    logic           ovf_q, ovf_d;
    logic           udf_q, udf_d;

    for (genvar i = 0; i < col; i++) begin : g_lane
        ofifo_lane #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .wr      (wr[i]),
            .din     (in[i*psum_bw +: psum_bw]),
            .rd      (rd_eff),
            .dout    (out[i*psum_bw +: psum_bw]),
            .empty   (empty[i]),
            .full    (full[i])
        );
    end

    // A row is complete only when no lane is empty; pops only happen then.
    assign o_valid = ~(|empty);
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign rd_eff  = rd & o_valid;
    assign o_ovf   = ovf_q;
    assign o_udf   = udf_q;

    // Sticky error detection: dropped write on a full lane, pop with no complete row.
    always_comb begin
        ovf_d = ovf_q | (|(wr & full & ~{col{rd_eff}}));
        udf_d = udf_q | (rd & ~o_valid);
    end

    // Sticky flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

endmodule

// File: doc/ofifo.md
# ofifo

Output FIFO between the MAC array's bottom row and the SFP stage. Each array column writes its 16-bit partial sum independently, whenever its own valid strobe fires. The block releases one full row (one entry per column) to the SFP only once every column holds data. The SFP consumes the row together with the matching PSUM SRAM word; `out` is its `ofifo_in` operand.

## Interface
- `col`, default 8: number of array columns / FIFO lanes.
- `psum_bw`, default 16: partial-sum width per lane; must equal the SFP `psum_bw`.
- `depth`, default 64: entries per lane; power of two, ≥ 2.
- `clk`  in  1: rising-edge clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `wr`  in  col: per-lane write strobe; bit *i* pushes `in[i]`.
- `in`  in  col*psum_bw: lane data; lane *i* occupies bits `[psum_bw*(i+1)-1 : psum_bw*i]`.
- `rd`  in  1: pop one row from all lanes at once.
- `out`  out  col*psum_bw: head row, same lane packing as `in`; first-word-fall-through.
- `o_valid`  out  1: every lane is non-empty, so `out` is a complete row.
- `o_full`  out  1: at least one lane is full.
- `o_ready`  out  1: equals `~o_full`; the array stalls on 0.
- `o_ovf`  out  1: sticky; a write was dropped.
- `o_udf`  out  1: sticky; `rd` was asserted with `o_valid`=0.

## Operation
- Each lane is a circular buffer of `depth` words.
  - Write and read pointers are log2(depth)+1 bits wide; the extra bit is a wrap bit.
  - Empty: pointers are fully equal.
  - Full: low bits are equal and wrap bits differ.
  - Pointers wrap from depth-1 to 0 with the wrap bit toggled.
- Lane write: `wr[i]` writes when the lane is not full, or when it is full and an effective read occurs in the same cycle. Otherwise the write is dropped, the lane is unchanged, and `o_ovf` is set.
- Effective read = `rd & o_valid`. It advances every lane's read pointer by one in the same cycle.
- `rd` with `o_valid`=0 is ignored: no pointer moves and `o_udf` is set.
- Simultaneous write and effective read on one lane: both happen and the occupancy is unchanged.
  - If the lane was empty, `o_valid` was 0, so there is no effective read.
  - A write into an empty lane is therefore never bypassed to `out` in the same cycle.
- `out` lane *i* = `mem_i[rd_ptr_i]`, read combinationally. Its value is undefined while `o_valid`=0; the bench must not check it then.
- Data is stored unmodified: no sign handling and no arithmetic.

## Timing
- Reset (`reset_n` low, asynchronous):
  - all pointers go to 0;
  - outputs: `o_valid`=0, `o_full`=0, `o_ready`=1, `o_ovf`=0, `o_udf`=0;
  - memory contents are not reset.
- Reset asserted mid-operation empties all lanes immediately. No partial row survives.
- Write latency: a push at edge N makes the lane non-empty after N. `o_valid` rises in the cycle after the edge at which the last empty lane was written.
- Read: `out` and `o_valid` reflect the popped state in the cycle after the `rd` edge. Back-to-back `rd` every cycle drains one row per cycle.
- `o_full`, `o_ready` and `o_valid` are decoded from registered pointers and are glitch-free relative to `clk`.
- `o_ovf` and `o_udf` are cleared only by reset.

## Structure
- A shared package `ofifo_pkg` holds:
  - the defaults for `col`, `psum_bw` and `depth`;
  - a `PTR_BW = $clog2(depth)+1` helper constant;
  - the lane-slice width constant reused by `sfp` and the PSUM SRAM wrapper.
- Sub-module `ofifo_lane`: one circular buffer with ports `wr`, `din`, `rd`, `dout`, `empty`, `full`. The top generates `col` instances.
- The top holds the all-lane AND (`o_valid`), the any-lane OR (`o_full`) and the two sticky flags.

## Test plan
- **Reset values**: hold `reset_n`=0, then release → `o_valid`=0, `o_ready`=1, `o_ovf`=0, `o_udf`=0.
- **Skewed columns**: `col`=8, write lane *i* with value 0x0100+*i* at cycle *i* (staggered diagonal) → `o_valid` stays 0 until the cycle after lane 7's write. `out` then holds 0x0107…0x0100 (lane 7 in the MSBs); one `rd` → `o_valid`=0.
- **Fill and drain with wrap**: `depth`=4, write 4 rows 0x1111·k, then write a 5th row → `o_full`=1, `o_ready`=0, `o_ovf`=1, 5th row dropped. Read 4 rows → values k=1..4 in order. Then write and read 6 more rows to cross the pointer wrap → order preserved and no flags change.
- **Simultaneous read/write on full lanes**: all lanes full, assert `rd` and `wr`=all-ones with value 0x7FFF → occupancy stays 4, `o_ovf` unchanged, and 0x7FFF emerges 4 reads later.
- **Underflow**: assert `rd` while empty → pointers unchanged and `o_udf`=1. A subsequent valid row still reads correctly.
- **Async reset mid-stream**: 2 rows queued, pulse `reset_n` low between clock edges → `o_valid` drops without waiting for a clock edge. A new write of 0xFFFF (−1) reads back as 0xFFFF, confirming the FIFO is empty and stores data unaltered.
